// File: rtl/std_logic_pkg.sv
// ---------------------------------------------------------------------------
// std_logic_pkg
// Shared definitions for the bitwise reducer family.
//   OP_*          2-bit operation codes carried alongside the data.
//   clog2         constant ceil(log2(value)), 0 for value <= 1.
//   num_levels    register levels of an n-operand tree: max(1, clog2(n)).
//   level_width   operand count entering tree level 'level' (level 0 = inputs).
//
// Identity-pass rule: when a tree level sees an odd number of operands, the
// last operand has no partner and is forwarded unchanged. This is equivalent
// to pairing it with the identity of the operation (all-ones for AND, zero
// for OR/XOR), so the result matches a flat reduction over all operands.
// ---------------------------------------------------------------------------
package std_logic_pkg;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    function automatic int num_levels(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int level_width(input int n, input int level);
        int m;
        m = n;
        for (int k = 0; k < level; k++) begin
            m = (m + 1) / 2;
        end
        return m;
    endfunction

endpackage

// File: rtl/std_reduce_pipe_if.sv
// ---------------------------------------------------------------------------
// std_reduce_pipe_if
// Input/output handshake bundle of the pipelined reducer.
//   in_valid/in_ready/x/op    upstream side (operands, operation select)
//   out_valid/out_ready/y     downstream side (reduction result)
// Modports: master = traffic source/sink, slave = reducer.
// ---------------------------------------------------------------------------
interface std_reduce_pipe_if #(
    parameter int N = 8,
    parameter int W = 1
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] x;
    logic [1:0]     op;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   y;

    modport master (
        output in_valid, x, op, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, op, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/std_reduce_stage.sv
// ---------------------------------------------------------------------------
// std_reduce_stage
// One registered level of the reduction tree: M operands of W bits are
// combined pairwise into ceil(M/2) operands.
//   clk, rstn   clock, asynchronous active-low reset
//   in_vld      previous level holds valid data
//   in_op       operation travelling with that data
//   in_data     M operands, operand i = in_data[i*W +: W]
//   nxt_load    downstream consumes this level's content this cycle
//   ready       this level loads from the previous one this cycle
//   vld/op/data registered level content (data inverted for NAND when LAST)
// ---------------------------------------------------------------------------
module std_reduce_stage
    import std_logic_pkg::*;
#(
    parameter int M    = 2,
    parameter int W    = 1,
    parameter bit LAST = 1'b0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_vld,
    input  logic [1:0]             in_op,
    input  logic [M*W-1:0]         in_data,
    input  logic                   nxt_load,
    output logic                   ready,
    output logic                   vld,
    output logic [1:0]             op,
    output logic [((M+1)/2)*W-1:0] data
);
    localparam int MO = (M + 1) / 2;

    logic              vld_d, vld_q;
    logic [1:0]        op_d, op_q;
    logic [MO*W-1:0]   data_d, data_q;
    logic [2*MO*W-1:0] pad;

    // NAND reduces like AND; its inversion happens at the tree output.
    function automatic logic [W-1:0] reduce_pair(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input logic         has_b,
                                                 input logic [1:0]   sel);
        logic [W-1:0] r;
        if (!has_b) begin
            r = a;
        end else begin
            case (sel)
                OP_OR:   r = a | b;
                OP_XOR:  r = a ^ b;
                default: r = a & b;
            endcase
        end
        return r;
    endfunction

    always_comb begin
        // A level accepts when empty or when its content moves on this cycle.
        ready  = !vld_q || nxt_load;
        vld_d  = ready ? in_vld : vld_q;
        op_d   = op_q;
        data_d = data_q;
        pad    = '0;
        pad[M*W-1:0] = in_data;
        if (ready && in_vld) begin
            op_d = in_op;
            for (int j = 0; j < MO; j++) begin
                data_d[j*W +: W] = reduce_pair(pad[2*j*W +: W], pad[(2*j+1)*W +: W],
                                               (2*j + 1) < M, in_op);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q  <= 1'b0;
            op_q   <= OP_AND;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            op_q   <= op_d;
            data_q <= data_d;
        end
    end

    assign vld  = vld_q;
    assign op   = op_q;
    assign data = (LAST && op_q == OP_NAND) ? ~data_q : data_q;

endmodule

// File: rtl/std_reduce_pipe.sv
// ---------------------------------------------------------------------------
// std_reduce_pipe
// Pipelined N-operand bitwise reduction (AND/OR/XOR/NAND) of W-bit operands,
// one register level per tree level, latency max(1, clog2(N)) cycles.
//   clk    clock, rising edge
//   rstn   asynchronous active-low reset
//   bus    std_reduce_pipe_if.slave: in_valid/in_ready/x/op, out_valid/out_ready/y
//   cnt    completed output transfers, saturating at 16'hFFFF
// Optional feature macro STD_REDUCE_STATS_EN: enables the cnt counter;
// without it cnt is tied to zero.
// ---------------------------------------------------------------------------
module std_reduce_pipe
    import std_logic_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rstn,
    std_reduce_pipe_if.slave bus,
    output logic [15:0]      cnt
);
    localparam int L = num_levels(N);

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int M  = level_width(N, k);
        localparam int MO = (M + 1) / 2;

        logic            in_vld;
        logic [1:0]      in_op;
        logic [M*W-1:0]  in_data;
        logic            nxt_load;
        logic            ready;
        logic            vld;
        logic [1:0]      op;
        logic [MO*W-1:0] data;

        if (k == 0) begin : g_head
            assign in_vld  = bus.in_valid;
            assign in_op   = bus.op;
            assign in_data = bus.x;
        end else begin : g_link
            assign in_vld  = g_lvl[k-1].vld;
            assign in_op   = g_lvl[k-1].op;
            assign in_data = g_lvl[k-1].data;
        end

        // Stall chain: a level drains when the next one is ready, the last
        // level when the consumer takes the result.
        if (k == L - 1) begin : g_tail
            assign nxt_load = bus.out_ready;
        end else begin : g_mid
            assign nxt_load = g_lvl[k+1].ready;
        end

        std_reduce_stage #(
            .M    (M),
            .W    (W),
            .LAST (k == L - 1)
        ) u_stage (
            .clk      (clk),
            .rstn     (rstn),
            .in_vld   (in_vld),
            .in_op    (in_op),
            .in_data  (in_data),
            .nxt_load (nxt_load),
            .ready    (ready),
            .vld      (vld),
            .op       (op),
            .data     (data)
        );
    end

    assign bus.in_ready  = g_lvl[0].ready;
    assign bus.out_valid = g_lvl[L-1].vld;
    assign bus.y         = g_lvl[L-1].data;

`ifdef STD_REDUCE_STATS_EN
    logic [15:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (g_lvl[L-1].vld && bus.out_ready && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`else
    assign cnt = 16'd0;
`endif

endmodule

// File: tb/tb_std_reduce_pipe.sv
module tb_std_reduce_pipe;

    localparam logic [1:0] C_AND  = 2'b00;
    localparam logic [1:0] C_OR   = 2'b01;
    localparam logic [1:0] C_XOR  = 2'b10;
    localparam logic [1:0] C_NAND = 2'b11;
`ifdef STD_REDUCE_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;

    always #5 clk = ~clk;

    std_reduce_pipe_if #(.N(8), .W(4)) ia ();
    std_reduce_pipe_if #(.N(5), .W(2)) ib ();
    std_reduce_pipe_if #(.N(8), .W(1)) ic ();
    std_reduce_pipe_if #(.N(1), .W(3)) id ();

    std_reduce_pipe #(.N(8), .W(4)) dut_a (.clk(clk), .rstn(rstn), .bus(ia), .cnt(cnt_a));
    std_reduce_pipe #(.N(5), .W(2)) dut_b (.clk(clk), .rstn(rstn), .bus(ib), .cnt(cnt_b));
    std_reduce_pipe #(.N(8), .W(1)) dut_c (.clk(clk), .rstn(rstn), .bus(ic), .cnt(cnt_c));
    std_reduce_pipe #(.N(1), .W(3)) dut_d (.clk(clk), .rstn(rstn), .bus(id), .cnt(cnt_d));

    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    int          n_chk   = 0;
    int          n_pass  = 0;
    logic [31:0] exp_q[$];
    int          out_cnt = 0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_y = '0;
    bit          acc_a = 1'b0;

    // Flat reduction over all operands: AND/OR/XOR are associative and
    // commutative, so the tree shape cannot change the answer.
    function automatic logic [31:0] ref_reduce(input logic [31:0] x, input logic [1:0] op,
                                               input int n, input int w);
        logic [31:0] mask, acc, opd;
        mask = (32'd1 << w) - 32'd1;
        acc  = (op == C_OR || op == C_XOR) ? 32'd0 : mask;
        for (int i = 0; i < n; i++) begin
            opd = (x >> (i * w)) & mask;
            case (op)
                C_OR:    acc = acc | opd;
                C_XOR:   acc = acc ^ opd;
                default: acc = acc & opd;
            endcase
        end
        if (op == C_NAND) acc = ~acc & mask;
        return acc;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add_vec(input int sel, input logic [1:0] op, input logic [31:0] x,
                           input logic [31:0] y, input int lat);
        vec_t v;
        v.sel = sel; v.op = op; v.x = x; v.y = y; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Scoreboard for dut_a, evaluated mid-cycle: a handshake seen here
    // completes at the following rising edge.
    task automatic mon_a();
        acc_a = 1'b0;
        if (ia.out_valid && ia.out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", 32'(ia.out_valid), 32'd0);
            else chk("result", 32'(ia.y), exp_q.pop_front());
            if (out_cnt < 65535) out_cnt++;
        end
        if (stall_prev) begin
            chk("stall_valid", 32'(ia.out_valid), 32'd1);
            chk("stall_y", 32'(ia.y), stall_y);
        end
        stall_prev = ia.out_valid && !ia.out_ready;
        stall_y    = 32'(ia.y);
        if (ia.in_valid && ia.in_ready) begin
            exp_q.push_back(ref_reduce(ia.x, ia.op, 8, 4));
            acc_a = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon_a();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ia.in_valid  = 1'b0;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(ia.out_valid), 32'd0);
    endtask

    // Single isolated transaction on one of the four instances.
    task automatic run_one(input int sel, input logic [1:0] op, input logic [31:0] x,
                           output logic [31:0] y, output int lat);
        logic        ov, rdy;
        logic [31:0] yy;
        case (sel)
            0: begin ia.x = x;      ia.op = op; ia.in_valid = 1'b1; end
            1: begin ib.x = x[9:0]; ib.op = op; ib.in_valid = 1'b1; end
            2: begin ic.x = x[7:0]; ic.op = op; ic.in_valid = 1'b1; end
            default: begin id.x = x[2:0]; id.op = op; id.in_valid = 1'b1; end
        endcase
        lat = -1;
        y   = '0;
        @(negedge clk);
        case (sel)
            0: rdy = ia.in_ready;
            1: rdy = ib.in_ready;
            2: rdy = ic.in_ready;
            default: rdy = id.in_ready;
        endcase
        chk("accept", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0; id.in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            case (sel)
                0: begin ov = ia.out_valid; yy = 32'(ia.y); end
                1: begin ov = ib.out_valid; yy = 32'(ib.y); end
                2: begin ov = ic.out_valid; yy = 32'(ic.y); end
                default: begin ov = id.out_valid; yy = 32'(id.y); end
            endcase
            if (ov) begin
                lat = i;
                y   = yy;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          guard;
        int          lat;
        logic [31:0] y;

        ia.in_valid = 1'b0; ia.x = '0; ia.op = C_AND; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.x = '0; ib.op = C_AND; ib.out_ready = 1'b1;
        ic.in_valid = 1'b0; ic.x = '0; ic.op = C_AND; ic.out_ready = 1'b1;
        id.in_valid = 1'b0; id.x = '0; id.op = C_AND; id.out_ready = 1'b1;

        // N=8, W=4
        add_vec(0, C_XOR,  32'h87654321, 32'h8, 3);
        add_vec(0, C_AND,  32'hFFFF7FFF, 32'h7, 3);
        add_vec(0, C_NAND, 32'hFFFF7FFF, 32'h8, 3);
        add_vec(0, C_OR,   32'h00000000, 32'h0, 3);
        add_vec(0, C_OR,   32'h00100000, 32'h1, 3);
        add_vec(0, C_AND,  32'hFFFFFFFF, 32'hF, 3);
        add_vec(0, C_NAND, 32'hFFFFFFFF, 32'h0, 3);
        add_vec(0, C_XOR,  32'h11111111, 32'h0, 3);
        add_vec(0, C_XOR,  32'h00000003, 32'h3, 3);
        // N=5, W=2 (unpaired operand 4)
        add_vec(1, C_AND,  32'h1FF, 32'h1, 3);
        add_vec(1, C_OR,   32'h200, 32'h2, 3);
        add_vec(1, C_XOR,  32'h139, 32'h1, 3);
        add_vec(1, C_NAND, 32'h3EF, 32'h1, 3);
        add_vec(1, C_XOR,  32'h300, 32'h3, 3);
        add_vec(1, C_AND,  32'h0FF, 32'h0, 3);
        // N=8, W=1
        add_vec(2, C_OR,   32'h10, 32'h1, 3);
        add_vec(2, C_XOR,  32'h07, 32'h1, 3);
        add_vec(2, C_AND,  32'hFF, 32'h1, 3);
        add_vec(2, C_NAND, 32'hFF, 32'h0, 3);
        add_vec(2, C_AND,  32'hFE, 32'h0, 3);
        add_vec(2, C_XOR,  32'h03, 32'h0, 3);
        // N=1, W=3
        add_vec(3, C_OR,   32'h5, 32'h5, 1);
        add_vec(3, C_NAND, 32'h5, 32'h2, 1);
        add_vec(3, C_XOR,  32'h3, 32'h3, 1);
        add_vec(3, C_AND,  32'h6, 32'h6, 1);

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid_a", 32'(ia.out_valid), 32'd0);
        chk("rst_y_a", 32'(ia.y), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_out_valid_b", 32'(ib.out_valid), 32'd0);
        chk("rst_out_valid_d", 32'(id.out_valid), 32'd0);
        rstn = 1'b1;
        #1;
        chk("rst_in_ready_a", 32'(ia.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed vectors
        foreach (vecs[i]) begin
            run_one(vecs[i].sel, vecs[i].op, vecs[i].x, y, lat);
            chk($sformatf("vec%0d_y", i), y, vecs[i].y);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end
        chk("cnt_a_vec", 32'(cnt_a), (STATS != 0) ? 32'd9 : 32'd0);
        chk("cnt_b_vec", 32'(cnt_b), (STATS != 0) ? 32'd6 : 32'd0);
        chk("cnt_c_vec", 32'(cnt_c), (STATS != 0) ? 32'd6 : 32'd0);
        chk("cnt_d_vec", 32'(cnt_d), (STATS != 0) ? 32'd4 : 32'd0);

        // Reset with three results in flight
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ia.x  = $urandom;
            ia.op = 2'($urandom_range(0, 3));
            step();
        end
        ia.in_valid = 1'b0;
        chk("inflight_count", 32'(exp_q.size()), 32'd3);
        chk("inflight_valid", 32'(ia.out_valid), 32'd1);
        #3 rstn = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(ia.out_valid), 32'd0);
        chk("async_rst_y", 32'(ia.y), 32'd0);
        chk("async_rst_cnt", 32'(cnt_a), 32'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        out_cnt    = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("no_stale", 32'(ia.out_valid), 32'd0);
        end

        // Back-to-back 16 with out_ready toggling, then a 5-cycle stall
        sent  = 0;
        guard = 0;
        ia.in_valid = 1'b1;
        ia.x  = $urandom;
        ia.op = 2'($urandom_range(0, 3));
        while (sent < 16 && guard < 100) begin
            ia.out_ready = (guard % 2 == 0);
            step();
            guard++;
            if (acc_a) begin
                sent++;
                ia.x  = $urandom;
                ia.op = 2'($urandom_range(0, 3));
            end
        end
        chk("b2b_sent", 32'(sent), 32'd16);
        ia.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (acc_a) begin
                ia.x  = $urandom;
                ia.op = 2'($urandom_range(0, 3));
            end
        end
        chk("stall_in_ready", 32'(ia.in_ready), 32'd0);
        chk("stall_occupancy", 32'(exp_q.size()), 32'd3);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            ia.in_valid  = ($urandom_range(0, 9) < 7);
            ia.x         = $urandom;
            ia.op        = 2'($urandom_range(0, 3));
            ia.out_ready = ($urandom_range(0, 9) < 6);
            step();
        end
        drain();
        chk("cnt_random", 32'(cnt_a), (STATS != 0) ? 32'(out_cnt) : 32'd0);

`ifdef STD_REDUCE_STATS_EN
        ia.in_valid  = 1'b1;
        ia.out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            ia.x  = $urandom;
            ia.op = 2'($urandom_range(0, 3));
            step();
        end
        drain();
        chk("cnt_saturated", 32'(cnt_a), 32'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
